// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the iterative multiply/divide unit.
//   mdu_op_e    - operation codes driven by the main decoder onto mdu_iter.op
//   mdu_state_e - sequencing states of mdu_iter
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one combinational radix-2 iteration of the multiply/divide datapath.
//   mode_div_i - 0: shift-add multiply step, 1: restoring divide step
//   acc_i      - 2*WIDTH accumulator {upper, lower}
//                multiply: {partial product, remaining multiplier bits}
//                divide:   {partial remainder, dividend/quotient bits}
//   operand_i  - multiplicand (multiply) or divisor (divide) magnitude
//   acc_o      - accumulator after this iteration
module mdu_step
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 mode_div_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     operand_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;

    always_comb begin
        // Carry out of the add is kept so the shift right brings it into the top bit.
        sum    = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + {1'b0, operand_i};
        // Shifted remainder needs WIDTH+1 bits; when the subtract succeeds the
        // result is below the divisor, so WIDTH bits of difference suffice.
        rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
        diff   = rem_sh[WIDTH-1:0] - operand_i;
        acc_o  = acc_i;
        if (mode_div_i) begin
            if (rem_sh >= {1'b0, operand_i}) begin
                acc_o = {diff, acc_i[WIDTH-2:0], 1'b1};
            end else begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (acc_i[0]) begin
                acc_o = {sum, acc_i[WIDTH-1:1]};
            end else begin
                acc_o = {1'b0, acc_i[2*WIDTH-1:1]};
            end
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.
//   clk, reset  - clock; synchronous active-high reset
//   start, op   - request an operation (accepted only when idle), op code
//   a, b        - rs / rt operands, captured on acceptance
//   hi_we,lo_we - MTHI/MTLO enables with write data wd (idle, no start only)
//   busy, done  - operation in flight / one-cycle completion pulse
//   hi, lo      - HI and LO registers
//
// state  | meaning
// S_IDLE | waiting; MTHI/MTLO writes allowed
// S_CALC | WIDTH iterations on magnitudes, counter WIDTH-1 down to 0
// S_FIX  | sign correction, write hi/lo, raise done
module mdu_iter
    import mdu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    mdu_state_e         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               div_q, div_d;
    logic               neg_q, neg_d;     // product / quotient is negative
    logic               rneg_q, rneg_d;   // remainder takes dividend sign
    logic               dz_q, dz_d;       // divide by zero
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    mdu_op_e            op_e;
    logic               sgn_op, sa, sb;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign op_e   = mdu_op_e'(op);
    assign sgn_op = op_is_signed(op_e);
    assign sa     = sgn_op & a[WIDTH-1];
    assign sb     = sgn_op & b[WIDTH-1];
    // The most negative value maps onto itself, which as an unsigned
    // magnitude is exactly 2^(WIDTH-1).
    assign mag_a  = sa ? -a : a;
    assign mag_b  = sb ? -b : b;

    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quo_fix  = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .mode_div_i (div_q),
        .acc_i      (acc_q),
        .operand_i  (opnd_q),
        .acc_o      (step_acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    div_d   = op_is_div(op_e);
                    neg_d   = sa ^ sb;
                    rneg_d  = sa;
                    dz_d    = (b == '0);
                    if (op_is_div(op_e)) begin
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                        opnd_d = mag_b;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                        opnd_d = mag_a;
                    end
                    cnt_d   = CW'(WIDTH - 1);
                    state_d = S_CALC;
                end else begin
                    if (hi_we) hi_d = wd;
                    if (lo_we) lo_d = wd;
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (div_q) begin
                    // With a zero divisor the remainder path has shifted the
                    // whole dividend through unchanged, so hi already equals a.
                    hi_d = rem_fix;
                    lo_d = dz_q ? {WIDTH{1'b1}} : quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
    import mdu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, hi_we, lo_we;
    logic [1:0]   op;
    logic [W-1:0] a, b, wd;
    logic         busy, done;
    logic [W-1:0] hi, lo;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    always #5 clk = ~clk;

    mdu_iter #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wd(wd),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural result {hi, lo} from plain integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [63:0] sx, sy, q, r;
        logic [63:0] ux, uy, uq, ur;
        sx = {{32{x[31]}}, x};
        sy = {{32{y[31]}}, y};
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            2'd0: return sx * sy;
            2'd1: return ux * uy;
            2'd2: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
        endcase
    endfunction

    // Issue one operation; optionally re-pulse start (with MTHI) while busy at
    // busy-cycle repulse_at, and/or raise hi_we/lo_we alongside start.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int repulse_at, input logic mt_at_start);
        logic [63:0] r;
        int busy_n;
        int guard;
        r = model(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        hi_we = mt_at_start; lo_we = mt_at_start; wd = $urandom;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = 2'($urandom); a = $urandom; b = $urandom;
        busy_n = 0;
        guard  = 0;
        while (done !== 1'b1 && guard < 100) begin
            if (busy === 1'b1) busy_n++;
            check({tag, " hold"}, {hi, lo}, {m_hi, m_lo});
            if (guard == repulse_at) begin
                start = 1'b1; op = MDU_MULTU; a = 32'd9; b = 32'd9;
                hi_we = 1'b1; wd = $urandom;
            end else begin
                start = 1'b0; hi_we = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        start = 1'b0; hi_we = 1'b0;
        check({tag, " no_timeout"}, 64'(guard < 100), 64'd1);
        check({tag, " busy_len"}, 64'(busy_n), 64'(W + 1));
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        m_hi = r[63:32];
        m_lo = r[31:0];
        check({tag, " hi"}, 64'(hi), 64'(m_hi));
        check({tag, " lo"}, 64'(lo), 64'(m_lo));
        @(negedge clk);
        check({tag, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dn;
        logic [1:0]   ro;
        logic [W-1:0] rx, ry;

        reset = 1'b1; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        op = '0; a = '0; b = '0; wd = '0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst hilo", {hi, lo}, 64'd0);
        reset = 1'b0;

        run_op("mult_neg", MDU_MULT, 32'hFFFF_FFFD, 32'h0000_0005, -1, 1'b0);
        check("mult_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("multu_max", MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
        check("multu_max const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        run_op("div_neg", MDU_DIV, 32'hFFFF_FFF9, 32'h0000_0002, -1, 1'b0);
        check("div_neg const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b0);
        check("div_ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
        run_op("divu_zero", MDU_DIVU, 32'h0000_0064, 32'h0, -1, 1'b0);
        check("divu_zero const", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
        run_op("div_zero_neg", MDU_DIV, 32'hFFFF_FF00, 32'h0, -1, 1'b0);
        run_op("mult_min", MDU_MULT, 32'h8000_0000, 32'h8000_0000, -1, 1'b0);

        run_op("repulse", MDU_MULTU, 32'd6, 32'd7, 5, 1'b0);
        check("repulse const", {hi, lo}, 64'h0000_0000_0000_002A);

        @(negedge clk); lo_we = 1'b1; wd = 32'h0000_1234;
        @(negedge clk); lo_we = 1'b0;
        m_lo = 32'h0000_1234;
        check("mtlo lo", 64'(lo), 64'(m_lo));
        check("mtlo hi", 64'(hi), 64'(m_hi));

        @(negedge clk); hi_we = 1'b1; lo_we = 1'b1; wd = 32'hCAFE_F00D;
        @(negedge clk); hi_we = 1'b0; lo_we = 1'b0;
        m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
        check("mthilo both", {hi, lo}, {m_hi, m_lo});

        run_op("start_with_mt", MDU_DIVU, 32'd1000, 32'd7, -1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if (i % 6 == 0) ry = '0;
            else if (i % 4 == 1) ry = W'($urandom_range(1, 20));
            else if (i % 5 == 2) ry = -W'($urandom_range(1, 20));
            run_op("random", ro, rx, ry, -1, 1'b0);
        end

        @(negedge clk); start = 1'b1; op = MDU_DIV; a = $urandom; b = $urandom_range(1, 1000);
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        check("abort busy", 64'(busy), 64'd0);
        check("abort hilo", {hi, lo}, {m_hi, m_lo});
        dn = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
        end
        check("abort no_done", 64'(dn), 64'd0);
        check("abort hilo_after", {hi, lo}, {m_hi, m_lo});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
